// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Turns EX/MEM load/store requests into a req/ack bus transaction, stalls the
// pipeline until the bus answers (or times out), formats load data and
// generates store byte strobes.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses trap
// without touching the bus instead of silently dropping out-of-word lanes).
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; bus fields latched on a request
// BUSY  | dmem_req asserted, waiting for dmem_ack or timeout
// DONE  | access_done pulse; EX/MEM still shows the old op, so no decode here
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] mem_address,
    input  logic [63:0] mem_write_data,
    input  logic [2:0]  funct3,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [63:0] load_data_out,
    output logic        access_done,
    output logic        bus_error,
    output logic        misalign_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [63:0]   dmem_addr_q, dmem_addr_d;
    logic [63:0]   dmem_wdata_q, dmem_wdata_d;
    logic [7:0]    dmem_wstrb_q, dmem_wstrb_d;
    logic [63:0]   load_data_q, load_data_d;
    logic          access_done_q, access_done_d;
    logic          bus_error_q, bus_error_d;
    logic          misalign_q, misalign_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [2:0]    lane_q, lane_d;

    logic [7:0]    size_mask;
    logic [7:0]    strb_shift;
    logic [63:0]   wdata_shift;
    logic [63:0]   lane_data;
    logic [63:0]   load_fmt;
    logic          misalign;

    // Store lane placement: bits pushed past byte 7 fall off the word.
    always_comb begin
        size_mask = 8'h00;
        case (funct3[1:0])
            2'b00: size_mask = 8'h01;
            2'b01: size_mask = 8'h03;
            2'b10: size_mask = 8'h0F;
            2'b11: size_mask = 8'hFF;
            default: size_mask = 8'h00;
        endcase
        strb_shift  = size_mask << mem_address[2:0];
        wdata_shift = mem_write_data << {mem_address[2:0], 3'b000};
    end

    // Load lane extract plus sign/zero extension, using the latched op.
    always_comb begin
        lane_data = dmem_rdata >> {lane_q, 3'b000};
        load_fmt  = 64'd0;
        case (funct3_q)
            3'b000: load_fmt = {{56{lane_data[7]}},  lane_data[7:0]};
            3'b001: load_fmt = {{48{lane_data[15]}}, lane_data[15:0]};
            3'b010: load_fmt = {{32{lane_data[31]}}, lane_data[31:0]};
            3'b011: load_fmt = lane_data;
            3'b100: load_fmt = {56'd0, lane_data[7:0]};
            3'b101: load_fmt = {48'd0, lane_data[15:0]};
            3'b110: load_fmt = {32'd0, lane_data[31:0]};
            default: load_fmt = 64'd0;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Natural-alignment check by access size.
    always_comb begin
        misalign = 1'b0;
        case (funct3)
            3'b001, 3'b101: misalign = mem_address[0];
            3'b010, 3'b110: misalign = |mem_address[1:0];
            3'b011:         misalign = |mem_address[2:0];
            default:        misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Next-state, stall and registered-output next values.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        dmem_wstrb_d  = dmem_wstrb_q;
        load_data_d   = load_data_q;
        access_done_d = 1'b0;
        bus_error_d   = 1'b0;
        misalign_d    = 1'b0;
        funct3_d      = funct3_q;
        lane_d        = lane_q;
        stall_out     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    stall_out = 1'b1;
                    funct3_d  = funct3;
                    lane_d    = mem_address[2:0];
                    if (misalign) begin
                        state_d       = DONE;
                        access_done_d = 1'b1;
                        misalign_d    = 1'b1;
                    end else begin
                        state_d      = BUSY;
                        wait_cnt_d   = '0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_write;
                        dmem_addr_d  = {mem_address[63:3], 3'b000};
                        dmem_wdata_d = wdata_shift;
                        dmem_wstrb_d = mem_write ? strb_shift : 8'h00;
                    end
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                if (dmem_ack) begin
                    state_d       = DONE;
                    dmem_req_d    = 1'b0;
                    access_done_d = 1'b1;
                    if (!dmem_we_q) begin
                        load_data_d = load_fmt;
                    end
                end else if (wait_cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    state_d       = DONE;
                    dmem_req_d    = 1'b0;
                    access_done_d = 1'b1;
                    bus_error_d   = 1'b1;
                    load_data_d   = 64'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also aborts an in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 64'd0;
            dmem_wdata_q  <= 64'd0;
            dmem_wstrb_q  <= 8'h00;
            load_data_q   <= 64'd0;
            access_done_q <= 1'b0;
            bus_error_q   <= 1'b0;
            misalign_q    <= 1'b0;
            funct3_q      <= 3'b000;
            lane_q        <= 3'b000;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            dmem_wstrb_q  <= dmem_wstrb_d;
            load_data_q   <= load_data_d;
            access_done_q <= access_done_d;
            bus_error_q   <= bus_error_d;
            misalign_q    <= misalign_d;
            funct3_q      <= funct3_d;
            lane_q        <= lane_d;
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_wstrb     = dmem_wstrb_q;
    assign load_data_out  = load_data_q;
    assign access_done    = access_done_q;
    assign bus_error      = bus_error_q;
    assign misalign_fault = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model of the expected
// per-cycle behaviour, a per-cycle compare process, directed spot checks
// with hand-computed values, and randomized load/store traffic.
module tb_mem_access_unit;

    localparam int TO = 6;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data;
    logic [2:0]  funct3;
    logic        stall_out, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata, load_data_out;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack, access_done, bus_error, misalign_fault;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .funct3(funct3), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .load_data_out(load_data_out), .access_done(access_done),
        .bus_error(bus_error), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // expected outputs for the current cycle
    bit          exp_en = 1'b0;
    logic        exp_stall, exp_req, exp_done, exp_err, exp_mis, exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_ldo;
    logic [7:0]  exp_strb;

    // captures from the most recent transaction
    int          cap_stall, cap_busy;
    bit          cap_req_seen;
    logic        cap_we, cap_err, cap_mis, cap_done;
    logic [63:0] cap_addr, cap_wdata, cap_ldo;
    logic [7:0]  cap_strb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_load(input logic [63:0] rd, input int off, input logic [2:0] f3);
        logic [63:0] v;
        int n;
        v = 64'd0;
        if (f3 == 3'd7) return v;
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++)
            if (off + k < 8) v[8*k +: 8] = rd[8*(off+k) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic m_store(input logic [63:0] addr, input logic [63:0] data, input logic [2:0] f3,
                           output logic [7:0] strb, output logic [63:0] wd);
        int off, n, j;
        off = int'(addr[2:0]);
        n = 1 << f3[1:0];
        strb = 8'h00;
        wd = 64'd0;
        for (int i = 0; i < 8; i++) begin
            j = i - off;
            if (j >= 0) wd[8*i +: 8] = data[8*j +: 8];
            if (j >= 0 && j < n) strb[i] = 1'b1;
        end
    endtask

    function automatic bit m_mis(input logic [63:0] addr, input logic [2:0] f3);
        int n;
        if (f3 == 3'd7) return 1'b0;
        n = 1 << f3[1:0];
        return (addr % n) != 0;
    endfunction

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (exp_en) begin
            check("stall_out", 64'(stall_out), 64'(exp_stall));
            check("dmem_req", 64'(dmem_req), 64'(exp_req));
            check("access_done", 64'(access_done), 64'(exp_done));
            check("bus_error", 64'(bus_error), 64'(exp_err));
            check("misalign_fault", 64'(misalign_fault), 64'(exp_mis));
            check("load_data_out", load_data_out, exp_ldo);
            if (exp_req) begin
                check("dmem_we", 64'(dmem_we), 64'(exp_we));
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_wstrb", 64'(dmem_wstrb), 64'(exp_strb));
                if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        if (stall_out) cap_stall++;
        if (dmem_req) begin
            cap_busy++;
            if (!cap_req_seen) begin
                cap_we = dmem_we; cap_addr = dmem_addr;
                cap_wdata = dmem_wdata; cap_strb = dmem_wstrb;
            end
            cap_req_seen = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
            dmem_rdata = {$urandom, $urandom};
            exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
            exp_err = 1'b0; exp_mis = 1'b0;
            @(negedge clk);
        end
    endtask

    // delay = BUSY cycle (1-based) carrying the ack; 0 = never ack
    task automatic do_op(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input logic [2:0] f3,
                         input int delay, input logic [63:0] ack_data);
        logic [7:0]  s;
        logic [63:0] wd;
        bit trap, acked;
        int k;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_write_data = data; funct3 = f3; dmem_ack = 1'b0;
        dmem_rdata = {$urandom, $urandom};
        m_store(addr, data, f3, s, wd);
        trap = TRAP && m_mis(addr, f3);
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_we = wr; exp_addr = {addr[63:3], 3'b000};
        exp_strb = wr ? s : 8'h00; exp_wdata = wd;
        cap_stall = 0; cap_busy = 0; cap_req_seen = 1'b0;
        sample();
        if (trap) begin
            @(posedge clk); #1;
            exp_stall = 1'b0; exp_done = 1'b1; exp_mis = 1'b1;
            sample();
        end else begin
            acked = 1'b0;
            k = 0;
            while (!acked && k < TO + 1) begin
                k++;
                @(posedge clk); #1;
                exp_stall = 1'b1; exp_req = 1'b1;
                acked = (delay == k);
                dmem_ack = acked;
                dmem_rdata = acked ? ack_data : {$urandom, $urandom};
                sample();
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            dmem_rdata = {$urandom, $urandom};
            exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1; exp_err = !acked;
            if (!acked) exp_ldo = 64'd0;
            else if (!wr) exp_ldo = m_load(ack_data, int'(addr[2:0]), f3);
            sample();
        end
        cap_ldo = load_data_out; cap_err = bus_error;
        cap_mis = misalign_fault; cap_done = access_done;
    endtask

    initial begin
        logic        r, w;
        logic [2:0]  f3;
        logic [63:0] a, d, msk;
        int          dl;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 64'd0;
        mem_write_data = 64'd0; funct3 = 3'd0; dmem_rdata = 64'd0; dmem_ack = 1'b0;

        // pin the model itself
        check("model_lb", m_load(64'h00000000_80000000, 3, 3'b000), 64'hFFFFFFFF_FFFFFF80);
        check("model_lhu_edge", m_load(64'hAB00_0000_0000_0000, 7, 3'b101), 64'h0000_0000_0000_00AB);
        check("model_ld", m_load(64'h0123_4567_89AB_CDEF, 0, 3'b011), 64'h0123_4567_89AB_CDEF);

        // reset state
        @(posedge clk); @(posedge clk); #1;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_mis = 1'b0; exp_ldo = 64'd0; exp_we = 1'b0;
        exp_en = 1'b1;
        @(negedge clk);
        check("rst_dmem_addr", dmem_addr, 64'd0);
        check("rst_dmem_wstrb", 64'(dmem_wstrb), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);

        // lb at 0x1003, ack in the first BUSY cycle
        do_op(1'b1, 1'b0, 64'h1003, 64'd0, 3'b000, 1, 64'h00000000_80000000);
        check("lb_load_data", cap_ldo, 64'hFFFFFFFF_FFFFFF80);
        check("lb_stall_cycles", 64'(cap_stall), 64'd2);
        check("lb_access_done", 64'(cap_done), 64'd1);

        // sh at 0x2006
        do_op(1'b0, 1'b1, 64'h2006, 64'h0000_0000_0000_BEEF, 3'b001, 2, 64'd0);
        check("sh_addr", cap_addr, 64'h2000);
        check("sh_wstrb", 64'(cap_strb), 64'hC0);
        check("sh_wdata", cap_wdata, 64'hBEEF0000_00000000);
        check("sh_we", 64'(cap_we), 64'd1);
        check("sh_load_data_kept", cap_ldo, 64'hFFFFFFFF_FFFFFF80);

        // lwu at 0x10, ack delayed 5 cycles (back-to-back with the store)
        do_op(1'b1, 1'b0, 64'h10, 64'd0, 3'b110, 5, 64'hCAFEBABE_87654321);
        check("lwu_stall_cycles", 64'(cap_stall), 64'd6);
        check("lwu_load_data", cap_ldo, 64'h00000000_87654321);

        // no ack: timeout after TO+1 BUSY cycles
        idle(1);
        do_op(1'b1, 1'b0, 64'h20, 64'd0, 3'b010, 0, 64'd0);
        check("to_busy_cycles", 64'(cap_busy), 64'(TO + 1));
        check("to_bus_error", 64'(cap_err), 64'd1);
        check("to_access_done", 64'(cap_done), 64'd1);
        check("to_load_data", cap_ldo, 64'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        do_op(1'b1, 1'b0, 64'h3004, 64'd0, 3'b011, 1, 64'h1111_2222_3333_4444);
        check("ld_mis_fault", 64'(cap_mis), 64'd1);
        check("ld_mis_no_req", 64'(cap_req_seen), 64'd0);
        check("ld_mis_stall", 64'(cap_stall), 64'd1);
        check("ld_mis_load_kept", cap_ldo, 64'd0);
`else
        do_op(1'b0, 1'b1, 64'h3004, 64'h0000_0000_1122_3344, 3'b011, 1, 64'd0);
        check("sd_mis_wstrb", 64'(cap_strb), 64'hF0);
        check("sd_mis_wdata", cap_wdata, 64'h11223344_00000000);
        check("sd_mis_fault", 64'(cap_mis), 64'd0);
`endif

        // reset during BUSY, ack arrives the cycle after reset
        do_op(1'b1, 1'b0, 64'h48, 64'd0, 3'b011, 1, 64'h5555_6666_7777_8888);
        exp_en = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 64'h40; funct3 = 3'b011;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; mem_read = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        check("rstbusy_req", 64'(dmem_req), 64'd0);
        check("rstbusy_stall", 64'(stall_out), 64'd0);
        check("rstbusy_done", 64'(access_done), 64'd0);
        @(posedge clk); #1; dmem_ack = 1'b0;
        @(negedge clk);
        check("rstbusy_done_after", 64'(access_done), 64'd0);
        check("rstbusy_req_after", 64'(dmem_req), 64'd0);
        check("rstbusy_load_data", load_data_out, 64'd0);
        exp_ldo = 64'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_en = 1'b1;

        // randomized traffic, including back-to-back ops and timeouts on loads
        for (int n = 0; n < 150; n++) begin
            r = 1'($urandom_range(0, 1));
            w = (!r) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
            f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            msk = (f3[1:0] == 2'b11) ? 64'hFFFF_FFFF_FFFF_FFFF
                                     : ((64'd1 << (8 << f3[1:0])) - 64'd1);
            d = {$urandom, $urandom} & msk;
            dl = w ? $urandom_range(1, 5) : $urandom_range(0, 5);
            do_op(r, w, a, d, f3, dl, {$urandom, $urandom});
            idle($urandom_range(0, 2));
        end

        idle(2);
        exp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
